// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: opcode and FSM state enums plus op classification helpers.
// Build option MDU_MADD_EN widens the opcode to add madd/maddu/msub/msubu.
package mdu_pkg;

    localparam int MDU_CNT_W = 4;

`ifdef MDU_MADD_EN
    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MFHI  = 4'd4,
        MD_MFLO  = 4'd5,
        MD_MTHI  = 4'd6,
        MD_MTLO  = 4'd7,
        MD_MADD  = 4'd8,
        MD_MADDU = 4'd9,
        MD_MSUB  = 4'd10,
        MD_MSUBU = 4'd11
    } md_op_e;
`else
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } mdu_state_e;

    function automatic logic op_is_mul(md_op_e op);
`ifdef MDU_MADD_EN
        return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
        return op inside {MD_MULT, MD_MULTU};
`endif
    endfunction

    function automatic logic op_is_div(md_op_e op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic op_is_signed(md_op_e op);
`ifdef MDU_MADD_EN
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
`else
        return op inside {MD_MULT, MD_DIV};
`endif
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and quotient/remainder of the latched MDU operands.
// Signedness follows the latched opcode; MDU_MADD_EN only affects which opcodes count as signed.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_e      op,
    output logic [63:0] prod,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic               sgn;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic        [63:0] qr;

    // Returns {remainder, quotient}; the most-negative / -1 case is pinned so the
    // overflowing quotient wraps to the dividend instead of trapping.
    function automatic logic [63:0] div_calc(logic [31:0] n, logic [31:0] d, logic s);
        logic signed [31:0] sn;
        logic signed [31:0] sd;
        logic        [31:0] q;
        logic        [31:0] r;
        sn = n;
        sd = d;
        if (d == 32'd0) begin
            q = '0;
            r = '0;
        end else if (s) begin
            if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
                q = n;
                r = '0;
            end else begin
                q = sn / sd;
                r = sn % sd;
            end
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    assign sgn      = op_is_signed(op);
    assign a_ext    = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    assign b_ext    = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    assign prod     = a_ext * b_ext;
    assign qr       = div_calc(a, b, sgn);
    assign quo      = qr[31:0];
    assign rem      = qr[63:32];
    assign div_zero = (b == 32'd0);

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: latches operands, runs a fixed-latency busy
// window, commits HI/LO and requests F/D stalls. MDU_MADD_EN adds multiply-accumulate ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = MDU_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     src_a,
    input  logic [31:0]     src_b,
    input  logic            d_is_md,
    output logic            busy,
    output logic            stall_req,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic [31:0]     md_out
);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      opa_q;
    logic [31:0]      opb_q;
    md_op_e           op_q;
    md_op_e           op_e;

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;
    logic [63:0] mul_res;

    assign op_e = md_op_e'(op);

    mdu_arith u_arith (
        .a        (opa_q),
        .b        (opb_q),
        .op       (op_q),
        .prod     (prod),
        .quo      (quo),
        .rem      (rem),
        .div_zero (div_zero)
    );

`ifdef MDU_MADD_EN
    // Accumulate uses HI/LO as they stand at the commit edge.
    always_comb begin
        mul_res = prod;
        case (op_q)
            MD_MADD, MD_MADDU: mul_res = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: mul_res = {hi, lo} - prod;
            default:           mul_res = prod;
        endcase
    end
`else
    assign mul_res = prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opa_q <= '0;
            opb_q <= '0;
            op_q  <= MD_MULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (op_is_mul(op_e)) begin
                            state <= ST_MUL_RUN;
                            cnt   <= CNT_W'(MULT_CYC - 1);
                            opa_q <= src_a;
                            opb_q <= src_b;
                            op_q  <= op_e;
                        end else if (op_is_div(op_e)) begin
                            state <= ST_DIV_RUN;
                            cnt   <= CNT_W'(DIV_CYC - 1);
                            opa_q <= src_a;
                            opb_q <= src_b;
                            op_q  <= op_e;
                        end else if (op_e == MD_MTHI) begin
                            hi <= src_a;
                        end else if (op_e == MD_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    if (cnt == '0) begin
                        {hi, lo} <= mul_res;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV_RUN: begin
                    if (cnt == '0) begin
                        // A zero divisor still burns the full latency but leaves HI/LO alone.
                        if (!div_zero) begin
                            hi <= rem;
                            lo <= quo;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign stall_req = d_is_md & (busy | (op_valid & (op_is_mul(op_e) | op_is_div(op_e))));

    always_comb begin
        md_out = '0;
        if (op_e == MD_MFHI) begin
            md_out = hi;
        end else if (op_e == MD_MFLO) begin
            md_out = lo;
        end
    end

endmodule
